// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-lane UART receiver: lane FSM states and the
// four comma codes that can be recognised per lane.
package uart_pkg;

  typedef enum logic [2:0] {
    StBreak,
    StIdle,
    StStart,
    StData,
    StStop
  } lane_state_e;

  localparam int unsigned COMMA_W = 10;

  localparam logic [COMMA_W-1:0] COMMA_0 = 10'b0011111010;
  localparam logic [COMMA_W-1:0] COMMA_1 = 10'b1100000101;
  localparam logic [COMMA_W-1:0] COMMA_2 = 10'b0011111001;
  localparam logic [COMMA_W-1:0] COMMA_3 = 10'b0011111000;

  function automatic logic [COMMA_W-1:0] comma_code(input logic [1:0] sel);
    case (sel)
      2'd0:    return COMMA_0;
      2'd1:    return COMMA_1;
      2'd2:    return COMMA_2;
      default: return COMMA_3;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_lane.sv
// One UART receive lane: 2-FF synchronizer, deframing FSM, bit-period counter and
// LSB-first shift register. o_done is a combinational strobe in the stop-sample cycle.
module uart_rx_lane
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned CLKDIV_W = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CLKDIV_W-1:0] i_clkdiv,
  input  logic                i_rx,
  output logic                o_done,
  output logic [DATA_W-1:0]   o_word,
  output logic                o_frame_err
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);

  lane_state_e         r_state, w_state_next;
  logic [1:0]          r_sync;
  logic [CLKDIV_W-1:0] r_div;
  logic [CLKDIV_W-1:0] r_cnt;
  logic [BitW-1:0]     r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_frame_err;
  logic                w_rx;
  logic                w_tick;
  logic                w_last_bit;
  logic                w_shift_en;
  logic                w_fe_set;
  logic [CLKDIV_W-1:0] w_start_cnt;

  assign w_rx        = r_sync[1];
  assign w_tick      = (r_cnt == '0);
  assign w_last_bit  = (r_bit == BitW'(DATA_W - 1));
  // First sample lands mid start bit, floor(div/2) cycles after the falling edge.
  assign w_start_cnt = (i_clkdiv >> 1) - CLKDIV_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StBreak;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StBreak: if (w_rx) w_state_next = StIdle;
      StIdle:  if (!w_rx) w_state_next = StStart;
      StStart: if (w_tick) w_state_next = w_rx ? StIdle : StData;
      StData:  if (w_tick && w_last_bit) w_state_next = StStop;
      StStop:  if (w_tick) w_state_next = w_rx ? StIdle : StBreak;
      default: w_state_next = StBreak;
    endcase
  end

  always_comb begin
    o_done     = 1'b0;
    w_fe_set   = 1'b0;
    w_shift_en = 1'b0;
    case (r_state)
      StData: w_shift_en = w_tick;
      StStop: begin
        o_done   = w_tick & w_rx;
        w_fe_set = w_tick & ~w_rx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= 2'b00;
      r_div       <= '0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_frame_err <= w_fe_set;
      case (r_state)
        StIdle: begin
          if (!w_rx) begin
            r_div <= i_clkdiv;
            r_cnt <= w_start_cnt;
            r_bit <= '0;
          end
        end
        StStart, StData, StStop: begin
          r_cnt <= w_tick ? (r_div - CLKDIV_W'(1)) : (r_cnt - CLKDIV_W'(1));
          if (w_shift_en) begin
            r_shift <= {w_rx, r_shift[DATA_W-1:1]};
            r_bit   <= r_bit + BitW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_word      = r_shift;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_rx_mlane.sv
// Multi-lane UART receiver top: per-lane holding registers, cross-lane alignment,
// comma compare and the valid/ready output stage with overrun detection.
module uart_rx_mlane
  import uart_pkg::*;
#(
  parameter int unsigned PORTCOUNT = 5,
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned CLKDIV_W  = 10
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CLKDIV_W-1:0]         clkdiv,
  input  logic [1:0]                  comma_sel,
  input  logic [PORTCOUNT-1:0]        uart_in,
  output logic [PORTCOUNT*DATA_W-1:0] data,
  output logic [PORTCOUNT-1:0]        comma,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic [PORTCOUNT-1:0]        frame_err,
  output logic [PORTCOUNT-1:0]        overrun_err,
  output logic                        rx_err
);

  logic [PORTCOUNT-1:0]             w_done;
  logic [PORTCOUNT-1:0][DATA_W-1:0] w_word;
  logic [PORTCOUNT-1:0]             w_fe;
  logic [PORTCOUNT-1:0]             w_comma_hit;
  logic                             w_xfer;

  logic [PORTCOUNT-1:0][DATA_W-1:0] r_hold;
  logic [PORTCOUNT-1:0]             r_hold_valid;
  logic [PORTCOUNT-1:0]             r_ovr;
  logic [PORTCOUNT*DATA_W-1:0]      r_data;
  logic [PORTCOUNT-1:0]             r_comma;
  logic                             r_data_valid;

  for (genvar i = 0; i < PORTCOUNT; i++) begin : g_lane
    uart_rx_lane #(
      .DATA_W  (DATA_W),
      .CLKDIV_W(CLKDIV_W)
    ) u_lane (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_clkdiv   (clkdiv),
      .i_rx       (uart_in[i]),
      .o_done     (w_done[i]),
      .o_word     (w_word[i]),
      .o_frame_err(w_fe[i])
    );
  end

  if (DATA_W == COMMA_W) begin : g_comma
    logic [COMMA_W-1:0] w_code;
    assign w_code = comma_code(comma_sel);
    for (genvar i = 0; i < PORTCOUNT; i++) begin : g_cmp
      assign w_comma_hit[i] = (r_hold[i] == w_code);
    end
  end else begin : g_no_comma
    assign w_comma_hit = '0;
  end

  assign w_xfer = (&r_hold_valid) & (~r_data_valid | data_ready);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold       <= '0;
      r_hold_valid <= '0;
      r_ovr        <= '0;
      r_data       <= '0;
      r_comma      <= '0;
      r_data_valid <= 1'b0;
    end else begin
      // A transfer frees every holding slot, so a same-cycle completion is never an overrun.
      r_ovr <= w_done & r_hold_valid & {PORTCOUNT{~w_xfer}};
      for (int i = 0; i < PORTCOUNT; i++) begin
        if (w_xfer) begin
          r_hold_valid[i] <= w_done[i];
          if (w_done[i]) r_hold[i] <= w_word[i];
        end else if (w_done[i] && !r_hold_valid[i]) begin
          r_hold[i]       <= w_word[i];
          r_hold_valid[i] <= 1'b1;
        end
      end
      if (w_xfer) begin
        r_data       <= r_hold;
        r_comma      <= w_comma_hit;
        r_data_valid <= 1'b1;
      end else if (data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign data        = r_data;
  assign comma       = r_comma;
  assign data_valid  = r_data_valid;
  assign frame_err   = w_fe;
  assign overrun_err = r_ovr;
  assign rx_err      = |(w_fe | r_ovr);

endmodule

// File: tb/tb_uart_rx_mlane.sv
// Scoreboard bench for uart_rx_mlane: directed frames push expected aligned words, a
// monitor compares them (data, comma, latency, stability) and tallies error pulses.
module tb_uart_rx_mlane;

  localparam int DIV = 10;
  localparam int LAT = 2 + DIV / 2 + 11 * DIV + 2;  // falling edge on pin to data_valid

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  clkdiv;
  logic [1:0]  comma_sel;
  logic [4:0]  uart_in;
  logic [49:0] data;
  logic [4:0]  comma;
  logic        data_valid;
  logic        data_ready;
  logic [4:0]  frame_err;
  logic [4:0]  overrun_err;
  logic        rx_err;

  uart_rx_mlane #(
    .PORTCOUNT(5),
    .DATA_W   (10),
    .CLKDIV_W (10)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .clkdiv     (clkdiv),
    .comma_sel  (comma_sel),
    .uart_in    (uart_in),
    .data       (data),
    .comma      (comma),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .rx_err     (rx_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [49:0] data;
    logic [4:0]  comma;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   fe_cnt[5];
  int   ov_cnt[5];
  int   tx_dly[5];
  logic pending = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: samples 1 time unit after the falling edge, away from the active edge.
  always @(negedge CLK) begin
    #1;
    if (!RST) begin
      for (int i = 0; i < 5; i++) begin
        if (frame_err[i]) fe_cnt[i]++;
        if (overrun_err[i]) ov_cnt[i]++;
      end
      if (rx_err || (|frame_err) || (|overrun_err))
        check("rx_err_or", {63'd0, rx_err}, {63'd0, (|frame_err) | (|overrun_err)});
      if (data_valid) begin
        if (q.size() == 0) begin
          check("unexpected_word", {63'd0, data_valid}, 64'd0);
        end else begin
          if (!pending) check("latency", 64'(cyc), 64'(q[0].cyc));
          check("data", {14'd0, data}, {14'd0, q[0].data});
          check("comma", {59'd0, comma}, {59'd0, q[0].comma});
          if (data_ready) begin
            void'(q.pop_front());
            pending = 1'b0;
          end else begin
            pending = 1'b1;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    @(negedge CLK);
    uart_in = '1;
    repeat (n) @(negedge CLK);
  endtask

  // Serialises one frame per enabled lane, lane l starting tx_dly[l] cycles in.
  task automatic drive(input logic [4:0] en, input logic [4:0][9:0] w, input logic [4:0] stopv,
                       input logic push, input logic [4:0][9:0] ew, input logic [4:0] ec);
    int max_d;
    int len;
    int k;
    exp_t e;
    max_d = 0;
    for (int l = 0; l < 5; l++) if (en[l] && tx_dly[l] > max_d) max_d = tx_dly[l];
    len = max_d + 12 * DIV;
    for (int t = 0; t < len; t++) begin
      @(negedge CLK);
      if (t == 0 && push) begin
        e.data  = ew;
        e.comma = ec;
        e.cyc   = cyc + max_d + LAT;
        q.push_back(e);
      end
      for (int l = 0; l < 5; l++) begin
        uart_in[l] = 1'b1;
        if (en[l] && t >= tx_dly[l]) begin
          k = (t - tx_dly[l]) / DIV;
          if (k == 0) uart_in[l] = 1'b0;
          else if (k <= 10) uart_in[l] = w[l][k-1];
          else if (k == 11) uart_in[l] = stopv[l];
        end
      end
    end
  endtask

  task automatic send_all(input logic [4:0][9:0] w, input logic [4:0] ec);
    drive(5'b11111, w, 5'b11111, 1'b1, w, ec);
  endtask

  logic [4:0][9:0] w;
  logic [4:0][9:0] ew;
  int              tmo;

  initial begin
    for (int i = 0; i < 5; i++) begin
      fe_cnt[i] = 0;
      ov_cnt[i] = 0;
      tx_dly[i] = 0;
    end
    RST        = 1'b1;
    clkdiv     = 10'(DIV);
    comma_sel  = 2'd0;
    uart_in    = '0;
    data_ready = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    check("rst_data", {14'd0, data}, 64'd0);
    check("rst_comma", {59'd0, comma}, 64'd0);
    check("rst_valid", {63'd0, data_valid}, 64'd0);
    check("rst_frame_err", {59'd0, frame_err}, 64'd0);
    check("rst_overrun", {59'd0, overrun_err}, 64'd0);
    check("rst_rx_err", {63'd0, rx_err}, 64'd0);
    repeat (50) @(negedge CLK);
    #1;
    check("low_line_valid", {63'd0, data_valid}, 64'd0);
    check("low_line_err", {63'd0, rx_err}, 64'd0);
    idle(20);

    // Aligned frames, then two more back-to-back.
    w = {10'b1100110011, 10'b0000111100, 10'b1111000011, 10'b1010101011, 10'b1101010100};
    send_all(w, 5'b00000);
    w = {10'b1111111111, 10'b1010101010, 10'b0101010101, 10'b1000000000, 10'b0000000001};
    send_all(w, 5'b00000);
    w = {10'b0110110110, 10'b1110001110, 10'b0011111001, 10'b0000000000, 10'b0011111010};
    send_all(w, 5'b00001);
    idle(20);

    // Skew plus backpressure.
    data_ready = 1'b0;
    tx_dly[0]  = 37;
    w = {10'b1001001001, 10'b0100100100, 10'b1011011011, 10'b0001110001, 10'b1110001110};
    send_all(w, 5'b00000);
    tx_dly[0] = 0;
    tmo = 0;
    while (!data_valid && tmo < 300) begin
      @(negedge CLK);
      tmo++;
    end
    check("skew_valid_seen", {63'd0, data_valid}, 64'd1);
    repeat (100) @(negedge CLK);
    data_ready = 1'b1;
    idle(20);

    // Comma detection under two selections.
    comma_sel = 2'd0;
    w = {10'd0, 10'd0, 10'b0011111010, 10'd0, 10'd0};
    send_all(w, 5'b00100);
    idle(10);
    comma_sel = 2'd3;
    w = {10'b0011111000, 10'd0, 10'd0, 10'b0011111010, 10'd0};
    send_all(w, 5'b10000);
    comma_sel = 2'd0;
    idle(20);

    // Framing error on lane 1, then recovery into its holding register.
    w = '0;
    w[1] = 10'b1010011100;
    drive(5'b00010, w, 5'b11101, 1'b0, w, 5'b0);
    idle(30);
    check("fe_lane1", 64'(fe_cnt[1]), 64'd1);
    check("fe_total", 64'(fe_cnt[0] + fe_cnt[2] + fe_cnt[3] + fe_cnt[4]), 64'd0);
    w[1] = 10'b0110011001;
    drive(5'b00010, w, 5'b11111, 1'b0, w, 5'b0);
    idle(20);

    // Short low glitch on lane 2.
    @(negedge CLK);
    uart_in[2] = 1'b0;
    repeat (3) @(negedge CLK);
    uart_in[2] = 1'b1;
    repeat (40) @(negedge CLK);
    check("glitch_fe", 64'(fe_cnt[2]), 64'd0);
    check("glitch_valid", {63'd0, data_valid}, 64'd0);

    // Overrun on lane 3; its first word must survive into the aligned output.
    w = '0;
    w[3] = 10'b0101010101;
    drive(5'b01000, w, 5'b11111, 1'b0, w, 5'b0);
    w[3] = 10'b1001100110;
    drive(5'b01000, w, 5'b11111, 1'b0, w, 5'b0);
    idle(10);
    check("ovr_lane3", 64'(ov_cnt[3]), 64'd1);
    check("ovr_total", 64'(ov_cnt[0] + ov_cnt[1] + ov_cnt[2] + ov_cnt[4]), 64'd0);
    w  = {10'b0000011111, 10'd0, 10'b0011111010, 10'd0, 10'b1000000001};
    ew = {10'b0000011111, 10'b0101010101, 10'b0011111010, 10'b0110011001, 10'b1000000001};
    drive(5'b10101, w, 5'b11111, 1'b1, ew, 5'b00100);

    tmo = 0;
    while (q.size() != 0 && tmo < 500) begin
      @(negedge CLK);
      tmo++;
    end
    idle(10);
    check("pending_words", 64'(q.size()), 64'd0);
    check("fe_final", 64'(fe_cnt[0] + fe_cnt[1] + fe_cnt[2] + fe_cnt[3] + fe_cnt[4]), 64'd1);
    check("ovr_final", 64'(ov_cnt[0] + ov_cnt[1] + ov_cnt[2] + ov_cnt[3] + ov_cnt[4]), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_mlane.md
# uart_rx_mlane

Multi-lane UART receiver, the parametrised successor of `uart_rx`, and the receive end of the chiplet serial link fed by `uart_tx`. Each lane independently deframes start / DATA_W bits LSB-first / stop at a runtime-programmable bit period. It flags framing errors and comma characters per lane. Completed words are aligned across lanes into one PORTCOUNT-wide word, delivered through a valid/ready handshake with per-lane overrun detection.

## Interface
Parameters:
- PORTCOUNT, 5, number of serial lanes
- DATA_W, 10, data bits per frame (comma detection only when 10)
- CLKDIV_W, 10, width of the bit-period divisor

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- clkdiv  in  CLKDIV_W  CLK cycles per bit; legal ≥ 4
- comma_sel  in  2  selects comma code compared per lane
- uart_in  in  PORTCOUNT  serial lines, asynchronous, idle high
- data  out  PORTCOUNT*DATA_W  aligned word; lane i at [i*DATA_W +: DATA_W]
- comma  out  PORTCOUNT  lane i word equals selected comma; qualified by data_valid
- data_valid  out  1  output word valid
- data_ready  in  1  consumer accepts when data_valid & data_ready
- frame_err  out  PORTCOUNT  1-cycle pulse, stop bit sampled 0
- overrun_err  out  PORTCOUNT  1-cycle pulse, new word dropped
- rx_err  out  1  OR of frame_err and overrun_err, same cycle

## Operation
- Each uart_in bit passes a 2-FF synchronizer; all sampling uses the synchronized value.
- Lane FSM: BREAK → IDLE → START → DATA → STOP → IDLE.
  - BREAK: the state after reset and after a frame error. Leave to IDLE on the first synchronized 1.
  - IDLE: on synchronized 0, latch clkdiv into the lane's divisor (clkdiv changes affect only later frames). Load counter; go to START.
  - START: sample at floor(div/2) cycles. If 1, it is a glitch: return to IDLE with no error. If 0, go to DATA.
  - DATA: sample every div cycles; shift in LSB-first; after DATA_W samples go to STOP.
  - STOP: sample after div cycles. If 1, the word is complete; go to IDLE. If 0, pulse frame_err[i], discard the word, go to BREAK.
- Holding stage:
  - Each lane has one holding register plus a hold_valid bit.
  - A completed word is written to holding if hold_valid=0.
  - If hold_valid=1, the word is dropped, overrun_err[i] pulses, and holding is unchanged.
- Alignment:
  - Transfer occurs when all hold_valid=1 and the output register is empty or being accepted this cycle.
  - The transfer loads data and comma (comparison of each held word against the comma_sel code at transfer time), sets data_valid, and clears all hold_valid.
  - A transfer cycle takes priority over a same-cycle lane completion: the completing lane writes into the freshly cleared holding register, with no overrun.
- data and comma hold stable while data_valid & !data_ready. data_valid clears on accept unless a transfer happens the same cycle.
- Comma codes (DATA_W=10; otherwise comma is tied 0): 0: 0011111010, 1: 1100000101, 2: 0011111001, 3: 0011111000.
- Reset mid-frame: all lanes return to BREAK; holding, output and error state are cleared.

## Timing
- Reset values: data=0, comma=0, data_valid=0, frame_err=0, overrun_err=0, rx_err=0; hold_valid=0, all lanes in BREAK.
- Synchronizer latency: 2 cycles.
- Stop-bit sample occurs floor(div/2) + (DATA_W+1)*div cycles after the synchronized falling edge.
- hold_valid sets the cycle after the stop sample.
- data_valid asserts the cycle after the last lane's hold_valid sets, given the output register is free.
- Back-to-back frames: the next start bit may follow the stop bit immediately. Sustained throughput is one word per (DATA_W+2)*div cycles when data_ready=1.
- Error pulses are exactly 1 cycle, registered, in the cycle after the offending sample or completion.

## Structure
- Package uart_pkg holds:
  - lane FSM enum (BREAK, IDLE, START, DATA, STOP)
  - the four 10-bit comma constants
  - COMMA_W = 10
- Sub-module uart_rx_lane contains one lane: synchronizer, FSM, divisor counter, shift register, done/frame_err outputs. It is instantiated PORTCOUNT times.
- The top level holds the holding registers, alignment, comma compare and output handshake.

## Test plan
- Reset: hold uart_in=0 through RST deassert for 50 cycles, then raise it. Require all outputs 0 and no word or error until the first full frame.
- Aligned frames, clkdiv=10, data_ready=1: send {1101010100,1010101011,1111000011,0000111100,1100110011}, then two further words back-to-back. Require each to appear exactly once with data_valid 1 cycle, at the latency above.
- Skew and backpressure: lane 0 starts 37 cycles after lane 4, with data_ready=0 for 100 cycles. Require a single aligned word, with data held stable until accept.
- Comma: comma_sel=0, lane 2 sends 0011111010 and the others send 0000000000. Require comma=5'b00100.
- Errors:
  - Lane 1 stop bit driven 0: frame_err[1] and rx_err pulse, no data_valid; the lane recovers on the next frame.
  - A 3-cycle low glitch produces no activity.
- Overrun: lane 3 sends 0101010101 then 1001100110 while the other lanes stay idle. Require overrun_err[3] on the second word, with holding retaining 0101010101.
